// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Program-memory loader. Accepts a valid/ready word stream and
//                writes it to consecutive memory addresses from a latched base
//                address, holding the CPU in programme mode for the whole load.
//                The optional trailing checksum beat is compiled in with the
//                macro PROG_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] base_addr_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] length_i,
    input  logic                            s_valid_i,
    input  logic [REGISTER_WIDTH-1:0]       s_data_i,
    output logic                            s_ready_o,
    output logic                            bl_programm_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
    output logic [REGISTER_WIDTH-1:0]       bl_data_o,
    output logic                            bl_write_en_mem_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    // Word counter must be able to hold a full-memory load (MEMORY_REGISTERS).
    localparam int CNT_WIDTH = $clog2(MEMORY_REGISTERS + 1);
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR  = MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
    localparam logic [CNT_WIDTH-1:0]            FULL_COUNT = CNT_WIDTH'(MEMORY_REGISTERS);
    localparam logic [CNT_WIDTH-1:0]            ONE_COUNT  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CKSUM  = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [MEMORY_ADDRESS_WIDTH-1:0] ptr, ptr_nxt, ptr_inc;
    logic [CNT_WIDTH-1:0]            remaining, remaining_nxt, load_count;
    logic                            ready, ready_nxt;
    logic                            programm, programm_nxt;
    logic [MEMORY_ADDRESS_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [REGISTER_WIDTH-1:0]       wr_data, wr_data_nxt;
    logic                            wr_en, wr_en_nxt;
    logic                            busy, busy_nxt;
    logic                            done, done_nxt;
    logic                            transfer;
    logic                            start_allowed;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [REGISTER_WIDTH-1:0] sum, sum_nxt, check_sum;
    logic                      error, error_nxt;

    assign check_sum     = sum + s_data_i;
    // A failed checksum parks the loader in ERROR until a new start or an abort.
    assign start_allowed = start_i && ((state == ST_IDLE) || (state == ST_ERROR));
`else
    assign start_allowed = start_i && (state == ST_IDLE);
`endif

    assign transfer = s_valid_i && ready;
    assign ptr_inc  = (ptr == LAST_ADDR) ? '0 : ptr + MEMORY_ADDRESS_WIDTH'(1);

    // Length 0 or anything beyond the memory depth means a full-memory load.
    always_comb begin
        load_count = CNT_WIDTH'(length_i);
        if ((length_i == '0) || (32'(length_i) > 32'(MEMORY_REGISTERS)))
            load_count = FULL_COUNT;
    end

    // Next state and next value of every registered output (outputs lag decisions by one cycle).
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        ready_nxt     = ready;
        programm_nxt  = programm;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        wr_en_nxt     = 1'b0;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_nxt       = sum;
        error_nxt     = error;
`endif
        if ((state != ST_IDLE) && abort_i) begin
            // Abort wins over a simultaneous transfer; written words are left alone.
            state_nxt    = ST_IDLE;
            ready_nxt    = 1'b0;
            programm_nxt = 1'b0;
            busy_nxt     = 1'b0;
        end else if (start_allowed) begin
            state_nxt     = ST_LOAD;
            ptr_nxt       = base_addr_i;
            remaining_nxt = load_count;
            ready_nxt     = 1'b1;
            programm_nxt  = 1'b1;
            busy_nxt      = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_nxt       = '0;
            error_nxt     = 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_nxt    = 1'b0;
                    programm_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                end
                ST_LOAD: begin
                    if (transfer) begin
                        wr_en_nxt     = 1'b1;
                        wr_addr_nxt   = ptr;
                        wr_data_nxt   = s_data_i;
                        ptr_nxt       = ptr_inc;
                        remaining_nxt = remaining - ONE_COUNT;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_nxt       = check_sum;
                        if (remaining == ONE_COUNT)
                            state_nxt = ST_CKSUM;
`else
                        if (remaining == ONE_COUNT) begin
                            state_nxt = ST_FINISH;
                            ready_nxt = 1'b0;
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    // The checksum beat is consumed but never written to memory.
                    if (transfer) begin
                        ready_nxt = 1'b0;
                        if (check_sum == '0) begin
                            state_nxt = ST_FINISH;
                        end else begin
                            state_nxt = ST_ERROR;
                            error_nxt = 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    // CPU stays held in programme mode while the error is pending.
                    ready_nxt    = 1'b0;
                    programm_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
`endif
                ST_FINISH: begin
                    // Release the CPU and pulse done in the cycle after the last strobe.
                    state_nxt    = ST_IDLE;
                    ready_nxt    = 1'b0;
                    programm_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b1;
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    ready_nxt    = 1'b0;
                    programm_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            remaining <= '0;
            ready     <= 1'b0;
            programm  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            ready     <= ready_nxt;
            programm  <= programm_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            wr_en     <= wr_en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running checksum accumulator and sticky error flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sum   <= '0;
            error <= 1'b0;
        end else begin
            sum   <= sum_nxt;
            error <= error_nxt;
        end
    end

    assign error_o = error;
`else
    assign error_o = 1'b0;
`endif

    assign s_ready_o         = ready;
    assign bl_programm_o     = programm;
    assign bl_address_o      = wr_addr;
    assign bl_data_o         = wr_data;
    assign bl_write_en_mem_o = wr_en;
    assign busy_o            = busy;
    assign done_o            = done;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Random data words are
//                streamed in; the expected write log (address, data) is built
//                from base + index modulo memory depth and compared against the
//                strobes observed on the memory write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int RW = 4;
    localparam int AW = 4;
    localparam int MR = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] length_i;
    logic          s_valid_i;
    logic [RW-1:0] s_data_i;
    logic          s_ready_o;
    logic          bl_programm_o;
    logic [AW-1:0] bl_address_o;
    logic [RW-1:0] bl_data_o;
    logic          bl_write_en_mem_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0] wr_q[$];
    int         wr_cyc[$];
    logic [7:0] exp_q[$];

    prog_loader #(
        .REGISTER_WIDTH      (RW),
        .MEMORY_ADDRESS_WIDTH(AW),
        .MEMORY_REGISTERS    (MR)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .base_addr_i      (base_addr_i),
        .length_i         (length_i),
        .s_valid_i        (s_valid_i),
        .s_data_i         (s_data_i),
        .s_ready_o        (s_ready_o),
        .bl_programm_o    (bl_programm_o),
        .bl_address_o     (bl_address_o),
        .bl_data_o        (bl_data_o),
        .bl_write_en_mem_o(bl_write_en_mem_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (bl_write_en_mem_o === 1'b1) begin
            wr_q.push_back({bl_address_o, bl_data_o});
            wr_cyc.push_back(cyc);
        end
        if (done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until a handshake; returns at the negedge after the transfer.
    task automatic send_word(input logic [RW-1:0] d, output bit ok);
        int t;
        t = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        while (s_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        ok = (s_ready_o === 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        s_data_i  = RW'($urandom);
    endtask

    task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input int gap,
                            input int abort_after, input bit mid_start, input string tag);
        int            eff;
        int            n;
        int            done0;
        int            sum;
        bit            ok;
        logic [RW-1:0] w;
        logic [7:0]    last;
        eff   = (len == 0) ? MR : int'(len);
        n     = (abort_after >= 0 && abort_after < eff) ? abort_after : eff;
        sum   = 0;
        done0 = done_cnt;
        wr_q.delete();
        wr_cyc.delete();
        exp_q.delete();

        start_i     = 1'b1;
        base_addr_i = base;
        length_i    = len;
        @(negedge clk_i);
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        length_i    = AW'($urandom);
        check({tag, "_busy_start"}, busy_o, 1);
        check({tag, "_prog_start"}, bl_programm_o, 1);
        check({tag, "_ready_start"}, s_ready_o, 1);

        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk_i);
            if (mid_start && i == 3) begin
                start_i     = 1'b1;
                base_addr_i = base + AW'(5);
                length_i    = AW'(1);
            end
            w = RW'($urandom);
            send_word(w, ok);
            start_i = 1'b0;
            if (!ok) check({tag, "_handshake"}, 0, 1);
            exp_q.push_back({AW'((int'(base) + i) % MR), w});
            sum = sum + int'(w);
        end

        if (n < eff) begin
            // Abort with a word offered at the same edge: the abort must win.
            abort_i   = 1'b1;
            s_valid_i = 1'b1;
            @(negedge clk_i);
            abort_i   = 1'b0;
            s_valid_i = 1'b0;
            check({tag, "_abort_prog"}, bl_programm_o, 0);
            check({tag, "_abort_ready"}, s_ready_o, 0);
            check({tag, "_abort_busy"}, busy_o, 0);
            check({tag, "_abort_we"}, bl_write_en_mem_o, 0);
            repeat (3) @(negedge clk_i);
            check({tag, "_abort_nodone"}, done_cnt, done0);
        end else begin
            check({tag, "_last_we"}, bl_write_en_mem_o, 1);
            check({tag, "_last_prog"}, bl_programm_o, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
            check({tag, "_ready_cksum"}, s_ready_o, 1);
            send_word(RW'((MR * 4 - sum) % (1 << RW)), ok);
            if (!ok) check({tag, "_cksum_handshake"}, 0, 1);
            check({tag, "_cksum_nowrite"}, bl_write_en_mem_o, 0);
            check({tag, "_cksum_prog"}, bl_programm_o, 1);
`endif
            check({tag, "_ready_drop"}, s_ready_o, 0);
            @(negedge clk_i);
            last = exp_q[exp_q.size() - 1];
            check({tag, "_done"}, done_o, 1);
            check({tag, "_prog_fall"}, bl_programm_o, 0);
            check({tag, "_busy_finish"}, busy_o, 1);
            check({tag, "_we_finish"}, bl_write_en_mem_o, 0);
            check({tag, "_addr_hold"}, bl_address_o, last[7:4]);
            check({tag, "_data_hold"}, bl_data_o, last[3:0]);
            @(negedge clk_i);
            check({tag, "_done_pulse"}, done_o, 0);
            check({tag, "_busy_idle"}, busy_o, 0);
            check({tag, "_done_count"}, done_cnt, done0 + 1);
        end

        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s_write%0d", tag, i), wr_q[i], exp_q[i]);
        if (gap == 0 && wr_cyc.size() == n && n > 0)
            check({tag, "_back_to_back"}, wr_cyc[n - 1] - wr_cyc[0], n - 1);
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic cksum_case(input logic [RW-1:0] ck, input string tag);
        bit ok;
        int done0;
        done0       = done_cnt;
        start_i     = 1'b1;
        base_addr_i = '0;
        length_i    = AW'(2);
        @(negedge clk_i);
        start_i = 1'b0;
        send_word(RW'(3), ok);
        send_word(RW'(5), ok);
        send_word(ck, ok);
        @(negedge clk_i);
        if (((3 + 5 + int'(ck)) % (1 << RW)) == 0) begin
            check({tag, "_done"}, done_o, 1);
            check({tag, "_err"}, error_o, 0);
        end else begin
            check({tag, "_err"}, error_o, 1);
            check({tag, "_prog_held"}, bl_programm_o, 1);
            check({tag, "_ready"}, s_ready_o, 0);
            repeat (2) @(negedge clk_i);
            check({tag, "_err_sticky"}, error_o, 1);
            check({tag, "_nodone"}, done_cnt, done0);
            start_i  = 1'b1;
            length_i = AW'(1);
            @(negedge clk_i);
            start_i = 1'b0;
            check({tag, "_err_clear"}, error_o, 0);
            check({tag, "_restart_busy"}, busy_o, 1);
            abort_i = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
            check({tag, "_abort_prog"}, bl_programm_o, 0);
        end
        repeat (2) @(negedge clk_i);
    endtask
`endif

    initial begin
        reset_i     = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
        s_valid_i   = 1'b1;
        s_data_i    = RW'($urandom);

        // Reset with a stray valid present.
        repeat (4) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("rst_ready", s_ready_o, 0);
        check("rst_prog", bl_programm_o, 0);
        check("rst_addr", bl_address_o, 0);
        check("rst_data", bl_data_o, 0);
        check("rst_we", bl_write_en_mem_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", error_o, 0);
        @(negedge clk_i);
        check("idle_valid_we", bl_write_en_mem_o, 0);
        check("idle_valid_writes", wr_q.size(), 0);
        s_valid_i = 1'b0;

        // Abort while idle is ignored.
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("idle_abort_busy", busy_o, 0);

        run_load(AW'(0),   AW'(4), 0, -1, 1'b0, "seq");
        run_load(AW'(14),  AW'(3), 2, -1, 1'b0, "wrap");
        run_load(AW'($urandom), AW'(0), 0, -1, 1'b1, "full");
        run_load(AW'($urandom), AW'(5), 1, 2, 1'b0, "abort");
        for (int k = 0; k < 4; k++)
            run_load(AW'($urandom), AW'($urandom), int'($urandom_range(2, 0)), -1, 1'b0,
                     $sformatf("rand%0d", k));

        // Asynchronous reset in the middle of a load.
        begin
            bit ok;
            start_i     = 1'b1;
            base_addr_i = AW'(2);
            length_i    = AW'(8);
            @(negedge clk_i);
            start_i = 1'b0;
            send_word(RW'($urandom), ok);
            #2 reset_i = 1'b0;
            #1;
            check("mid_rst_prog", bl_programm_o, 0);
            check("mid_rst_busy", busy_o, 0);
            check("mid_rst_ready", s_ready_o, 0);
            check("mid_rst_addr", bl_address_o, 0);
            check("mid_rst_we", bl_write_en_mem_o, 0);
            @(negedge clk_i);
            reset_i = 1'b1;
            repeat (2) @(negedge clk_i);
            check("post_rst_busy", busy_o, 0);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        cksum_case(RW'(8), "cks_ok");
        cksum_case(RW'(7), "cks_bad");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
